// File: rtl/spi_bus_arb_pkg.sv
// Shared types and constants for the INERT / A2D SPI bus arbiter.
package spi_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INERT = 1'b0,
    OWN_A2D   = 1'b1
  } owner_t;

  localparam logic [15:0] RST_WORD    = 16'h0000;
  localparam logic [15:0] TMO_RD_DATA = 16'hFFFF;

endpackage

// File: rtl/spi_bus_arb_if.sv
// Requester handshakes plus the SPI_mstr16 start/complete bus seen by the arbiter.
interface spi_bus_arb_if;
  logic        req_inert;
  logic [15:0] cmd_inert;
  logic        req_a2d;
  logic [15:0] cmd_a2d;
  logic        done_inert;
  logic        done_a2d;
  logic [15:0] rd_data;
  logic        busy;
  logic        tmo_err;
  logic        clr_err;
  logic        wrt;
  logic [15:0] cmd;
  logic        mstr_done;
  logic [15:0] mstr_rd_data;

  modport master (
    input  req_inert, cmd_inert, req_a2d, cmd_a2d, clr_err, mstr_done, mstr_rd_data,
    output done_inert, done_a2d, rd_data, busy, tmo_err, wrt, cmd
  );

  modport slave (
    output req_inert, cmd_inert, req_a2d, cmd_a2d, clr_err, mstr_done, mstr_rd_data,
    input  done_inert, done_a2d, rd_data, busy, tmo_err, wrt, cmd
  );
endinterface

// File: rtl/spi_bus_arb_pick.sv
// Winner select for the two requesters, with a starvation counter that forces A2D through.
module spi_bus_arb_pick
  import spi_bus_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_inert,
  input  logic req_a2d,
  input  logic grant,
  output logic pick_a2d
);
  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;

  // A lone requester always wins; on contention INERT wins until A2D has been passed over enough.
  assign pick_a2d = req_a2d && (!req_inert || (starve_cnt_r == CNT_MAX));

  // Starvation count: bumps when INERT beats a waiting A2D, clears when A2D is granted.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (grant) begin
      if (pick_a2d) begin
        starve_cnt_nxt_s = {CNT_W{1'b0}};
      end else if (req_a2d && (starve_cnt_r != CNT_MAX)) begin
        starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_nxt_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

endmodule

// File: rtl/spi_bus_arb.sv
// Shares one SPI_mstr16 between INERT and A2D: per-transaction grant, start/complete sequencing,
// read-data return and a watchdog that aborts transfers whose master never completes.
module spi_bus_arb
  import spi_bus_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TMO_W      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_bus_arb_if.master bus
);
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

  arb_state_t       state_r, state_nxt_s;
  owner_t           owner_r, owner_nxt_s;
  logic [15:0]      cmd_r, cmd_nxt_s;
  logic [15:0]      rd_data_r, rd_data_nxt_s;
  logic             wrt_r, wrt_nxt_s;
  logic             done_inert_r, done_inert_nxt_s;
  logic             done_a2d_r, done_a2d_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             tmo_err_r, tmo_err_nxt_s;
  logic             tmo_set_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic             grant_s;
  logic             pick_a2d_s;

  assign grant_s = (state_r == ST_IDLE) && (bus.req_inert || bus.req_a2d);

  spi_bus_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_inert(bus.req_inert),
    .req_a2d  (bus.req_a2d),
    .grant    (grant_s),
    .pick_a2d (pick_a2d_s)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    cmd_nxt_s        = cmd_r;
    rd_data_nxt_s    = rd_data_r;
    wrt_nxt_s        = 1'b0;
    done_inert_nxt_s = 1'b0;
    done_a2d_nxt_s   = 1'b0;
    busy_nxt_s       = busy_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    tmo_set_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s   = ST_XFER;
          owner_nxt_s   = pick_a2d_s ? OWN_A2D : OWN_INERT;
          cmd_nxt_s     = pick_a2d_s ? bus.cmd_a2d : bus.cmd_inert;
          wrt_nxt_s     = 1'b1;
          busy_nxt_s    = 1'b1;
          tmo_cnt_nxt_s = {TMO_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_XFER: begin
        // A completion landing on the watchdog's last cycle still counts as a clean finish.
        if (bus.mstr_done || (tmo_cnt_r == TMO_MAX)) begin
          state_nxt_s      = ST_GAP;
          rd_data_nxt_s    = bus.mstr_done ? bus.mstr_rd_data : TMO_RD_DATA;
          tmo_set_s        = !bus.mstr_done;
          done_inert_nxt_s = (owner_r == OWN_INERT);
          done_a2d_nxt_s   = (owner_r == OWN_A2D);
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ST_GAP: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
    if (tmo_set_s) begin
      tmo_err_nxt_s = 1'b1;
    end else if (bus.clr_err) begin
      tmo_err_nxt_s = 1'b0;
    end else begin
      tmo_err_nxt_s = tmo_err_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs, owner and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= OWN_INERT;
      cmd_r        <= RST_WORD;
      rd_data_r    <= RST_WORD;
      wrt_r        <= 1'b0;
      done_inert_r <= 1'b0;
      done_a2d_r   <= 1'b0;
      busy_r       <= 1'b0;
      tmo_err_r    <= 1'b0;
      tmo_cnt_r    <= {TMO_W{1'b0}};
    end else begin
      owner_r      <= owner_nxt_s;
      cmd_r        <= cmd_nxt_s;
      rd_data_r    <= rd_data_nxt_s;
      wrt_r        <= wrt_nxt_s;
      done_inert_r <= done_inert_nxt_s;
      done_a2d_r   <= done_a2d_nxt_s;
      busy_r       <= busy_nxt_s;
      tmo_err_r    <= tmo_err_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
    end
  end

  assign bus.wrt        = wrt_r;
  assign bus.cmd        = cmd_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.done_inert = done_inert_r;
  assign bus.done_a2d   = done_a2d_r;
  assign bus.busy       = busy_r;
  assign bus.tmo_err    = tmo_err_r;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_spi_bus_arb;
  localparam int STARVE_MAX = 4;
  localparam int TMO_W      = 6;
  localparam int TMO_CYC    = 1 << TMO_W;
  localparam int WAIT_MAX   = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n_wrt = 0;
  int   n_done_i = 0;
  int   n_done_a = 0;
  int   done_log[$];
  int   grant_log[$];

  spi_bus_arb_if bus();

  spi_bus_arb #(.STARVE_MAX(STARVE_MAX), .TMO_W(TMO_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  // Reference model: a transaction is either waiting for a grant, in flight (age in cycles since wrt),
  // or in its one-cycle completion gap.
  bit          m_act = 1'b0;
  bit          m_gap = 1'b0;
  bit          m_own_a2d = 1'b0;
  bit          m_set = 1'b0;
  int          m_age = 0;
  int          m_starve = 0;
  logic        e_wrt = 1'b0, e_di = 1'b0, e_da = 1'b0, e_busy = 1'b0, e_tmo = 1'b0;
  logic [15:0] e_cmd = 16'h0000, e_rd = 16'h0000;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 1'b0; m_gap = 1'b0; m_age = 0; m_starve = 0;
        e_wrt = 1'b0; e_di = 1'b0; e_da = 1'b0; e_busy = 1'b0; e_tmo = 1'b0;
        e_cmd = 16'h0000; e_rd = 16'h0000;
      end else begin
        m_set = 1'b0;
        e_wrt = 1'b0; e_di = 1'b0; e_da = 1'b0;
        if (m_gap) begin
          m_gap  = 1'b0;
          e_busy = 1'b0;
        end else if (m_act) begin
          if (bus.mstr_done === 1'b1 || m_age == TMO_CYC - 1) begin
            e_rd  = (bus.mstr_done === 1'b1) ? bus.mstr_rd_data : 16'hFFFF;
            m_set = (bus.mstr_done !== 1'b1);
            e_di  = !m_own_a2d;
            e_da  = m_own_a2d;
            m_act = 1'b0;
            m_gap = 1'b1;
          end else begin
            m_age = m_age + 1;
          end
        end else if (bus.req_inert === 1'b1 || bus.req_a2d === 1'b1) begin
          m_own_a2d = (bus.req_a2d === 1'b1) && (bus.req_inert !== 1'b1 || m_starve >= STARVE_MAX);
          if (m_own_a2d) m_starve = 0;
          else if (bus.req_a2d === 1'b1 && m_starve < STARVE_MAX) m_starve = m_starve + 1;
          grant_log.push_back(int'(m_own_a2d));
          e_cmd  = m_own_a2d ? bus.cmd_a2d : bus.cmd_inert;
          e_wrt  = 1'b1;
          e_busy = 1'b1;
          m_act  = 1'b1;
          m_age  = 0;
        end
        if (m_set) e_tmo = 1'b1;
        else if (bus.clr_err === 1'b1) e_tmo = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      total++;
      if ({bus.wrt, bus.done_inert, bus.done_a2d, bus.busy, bus.tmo_err} !== {e_wrt, e_di, e_da, e_busy, e_tmo}
          || bus.cmd !== e_cmd || bus.rd_data !== e_rd) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got wrt=%b di=%b da=%b busy=%b tmo=%b cmd=%h rd=%h required wrt=%b di=%b da=%b busy=%b tmo=%b cmd=%h rd=%h",
                 $time, bus.wrt, bus.done_inert, bus.done_a2d, bus.busy, bus.tmo_err, bus.cmd, bus.rd_data,
                 e_wrt, e_di, e_da, e_busy, e_tmo, e_cmd, e_rd);
      end
      if (bus.wrt === 1'b1) n_wrt++;
      if (bus.done_inert === 1'b1) begin n_done_i++; done_log.push_back(0); end
      if (bus.done_a2d === 1'b1) begin n_done_a++; done_log.push_back(1); end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL sim_timeout: got no finish, required finish before 1ms");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Returns on the negedge where wrt is seen; lat = negedges waited beyond the first.
  task automatic wait_wrt(input string nm, output int lat);
    lat = 0;
    @(negedge clk);
    while (bus.wrt !== 1'b1 && lat < WAIT_MAX) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_wrt_seen"}, 32'(bus.wrt), 32'd1);
  endtask

  // SPI_mstr16 stand-in: completes lat cycles after the wrt cycle; returns early in the gap cycle.
  task automatic finish_after(input int lat, input logic [15:0] rd);
    repeat (lat) @(posedge clk);
    #1;
    bus.mstr_rd_data = rd;
    bus.mstr_done    = 1'b1;
    @(posedge clk);
    #1;
    bus.mstr_done = 1'b0;
  endtask

  task automatic wait_done(input bit a2d, output int n);
    n = 0;
    while ((a2d ? bus.done_a2d : bus.done_inert) !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : stim
    int lat;
    int n;
    int nw;
    int nda;
    int ndi;
    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    bus.req_inert = 1'b0; bus.cmd_inert = 16'h0000;
    bus.req_a2d   = 1'b0; bus.cmd_a2d   = 16'h0000;
    bus.clr_err   = 1'b0; bus.mstr_done = 1'b0; bus.mstr_rd_data = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_wrt",  32'(bus.wrt), 32'd0);
    chk("reset_cmd",  32'(bus.cmd), 32'h0000);
    chk("reset_rd",   32'(bus.rd_data), 32'h0000);
    chk("reset_tmo",  32'(bus.tmo_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single INERT transaction, 40-cycle master
    bus.cmd_inert = 16'hA5A5;
    bus.req_inert = 1'b1;
    wait_wrt("t1", lat);
    chk("t1_latency", 32'(lat), 32'd0);
    chk("t1_cmd", 32'(bus.cmd), 32'hA5A5);
    finish_after(40, 16'h1234);
    bus.req_inert = 1'b0;
    @(negedge clk);
    chk("t1_done", 32'(bus.done_inert), 32'd1);
    chk("t1_busy_gap", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_low", 32'(bus.busy), 32'd0);
    chk("t1_rd", 32'(bus.rd_data), 32'h1234);
    chk("t1_nwrt", 32'(n_wrt), 32'd1);
    chk("t1_ndone_i", 32'(n_done_i), 32'd1);
    chk("t1_ndone_a", 32'(n_done_a), 32'd0);

    // 2: both held continuously -> starvation pattern
    done_log.delete();
    grant_log.delete();
    bus.cmd_inert = 16'h1111;
    bus.cmd_a2d   = 16'h2222;
    bus.req_inert = 1'b1;
    bus.req_a2d   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_wrt("t2", lat);
      finish_after(3, 16'h0100 + 16'(i));
    end
    bus.req_inert = 1'b0;
    bus.req_a2d   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_ndone", 32'(done_log.size()), 32'd10);
    chk("t2_ngrant_model", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < done_log.size()) chk($sformatf("t2_order_%0d", i), 32'(done_log[i]), 32'(exp_order[i]));
      if (i < grant_log.size()) chk($sformatf("t2_model_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
    end

    // 3: master never completes; clr_err held high across the abort (set must win)
    bus.cmd_a2d = 16'h3C3C;
    bus.req_a2d = 1'b1;
    bus.clr_err = 1'b1;
    wait_wrt("t3", lat);
    wait_done(1'b1, n);
    chk("t3_tmo_cycles", 32'(n), 32'(TMO_CYC));
    chk("t3_rd", 32'(bus.rd_data), 32'hFFFF);
    chk("t3_tmo_set", 32'(bus.tmo_err), 32'd1);
    bus.req_a2d = 1'b0;
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("t3_tmo_sticky", 32'(bus.tmo_err), 32'd1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("t3_tmo_clr", 32'(bus.tmo_err), 32'd0);
    bus.cmd_inert = 16'h0ACE;
    bus.req_inert = 1'b1;
    wait_wrt("t3b", lat);
    finish_after(5, 16'h5555);
    bus.req_inert = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3b_rd", 32'(bus.rd_data), 32'h5555);
    chk("t3b_tmo", 32'(bus.tmo_err), 32'd0);

    // 4: mstr_done on the watchdog's final cycle
    bus.cmd_inert = 16'hC0DE;
    bus.req_inert = 1'b1;
    wait_wrt("t4", lat);
    finish_after(TMO_CYC - 1, 16'hBEEF);
    bus.req_inert = 1'b0;
    @(negedge clk);
    chk("t4_done", 32'(bus.done_inert), 32'd1);
    @(negedge clk);
    chk("t4_rd", 32'(bus.rd_data), 32'hBEEF);
    chk("t4_tmo", 32'(bus.tmo_err), 32'd0);

    // 5: A2D drops req mid-transfer; INERT pulses req in the gap only; stray mstr_done in IDLE
    nda = n_done_a;
    bus.cmd_a2d = 16'h7777;
    bus.req_a2d = 1'b1;
    wait_wrt("t5", lat);
    bus.req_a2d = 1'b0;
    finish_after(10, 16'h4242);
    bus.req_inert = 1'b1;
    @(posedge clk);
    #1;
    bus.req_inert = 1'b0;
    nw = n_wrt;
    repeat (6) @(negedge clk);
    chk("t5_no_grant", 32'(n_wrt), 32'(nw));
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done_a", 32'(n_done_a), 32'(nda + 1));
    @(posedge clk);
    #1;
    bus.mstr_rd_data = 16'hDEAD;
    bus.mstr_done    = 1'b1;
    @(posedge clk);
    #1;
    bus.mstr_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_stray_rd", 32'(bus.rd_data), 32'h4242);

    // 6: async reset in the middle of a transfer
    ndi = n_done_i;
    bus.cmd_inert = 16'h9999;
    bus.req_inert = 1'b1;
    wait_wrt("t6", lat);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_cmd", 32'(bus.cmd), 32'h0000);
    chk("t6_rst_rd", 32'(bus.rd_data), 32'h0000);
    chk("t6_rst_done", 32'(bus.done_inert), 32'd0);
    bus.req_inert = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(n_done_i), 32'(ndi));
    bus.cmd_inert = 16'h6666;
    bus.req_inert = 1'b1;
    wait_wrt("t6b", lat);
    chk("t6b_latency", 32'(lat), 32'd0);
    chk("t6b_cmd", 32'(bus.cmd), 32'h6666);
    finish_after(8, 16'h0F0F);
    bus.req_inert = 1'b0;
    @(negedge clk);
    chk("t6b_done", 32'(bus.done_inert), 32'd1);
    @(negedge clk);
    chk("t6b_rd", 32'(bus.rd_data), 32'h0F0F);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
